uart_cmd_wrapper: RTL

Serial front end for the command processor. Deserialises 8N1 UART bytes from the host into 24-bit commands presented on `cmd`/`cmd_rdy`, held until the processor asserts `clr_cmd_rdy`. Serialises single-byte responses requested via `send_resp`/`resp_data` onto TX and reports completion on `resp_sent`. It is the host-side counterpart of the command decoder's `cmd`/`resp` handshake.

---
 rtl/uart_cmd_wrapper.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_wrapper.sv
// UART front end: 8N1 receiver assembling 24-bit commands and a single-byte
// response transmitter, sharing nothing but the clock and reset.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    output logic        resp_sent
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    state_e        rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          byte_ok, byte_bad;

    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   cmd_q, cmd_d;
    logic          cmd_rdy_q, cmd_rdy_d;

    state_e        tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d;
    logic          resp_sent_q, resp_sent_d;

    // rx_prev_q trails the synchronised line for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        unique case (rx_st_q)
            IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_d  = START;
                    rx_cnt_d = HALF;
                end
            end
            START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s2_q) begin
                        rx_st_d = IDLE;
                    end else begin
                        rx_st_d  = DATA;
                        rx_cnt_d = FULL;
                        rx_bit_d = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - ONE;
                end
            end
            DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = FULL;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - ONE;
                end
            end
            STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_st_d  = IDLE;
                    byte_ok  = rx_s2_q;
                    byte_bad = !rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - ONE;
                end
            end
            default: rx_st_d = IDLE;
        endcase
    end

    // A held command is never overwritten; the set of cmd_rdy beats a clear
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (byte_bad) begin
            byte_cnt_d = 2'd0;
        end else if (byte_ok && !cmd_rdy_q) begin
            if (byte_cnt_q == 2'd0) begin
                cmd_d[23:16] = rx_sh_q;
                byte_cnt_d   = 2'd1;
            end else if (byte_cnt_q == 2'd1) begin
                cmd_d[15:8] = rx_sh_q;
                byte_cnt_d  = 2'd2;
            end else begin
                cmd_d[7:0] = rx_sh_q;
                byte_cnt_d = 2'd0;
                cmd_rdy_d  = 1'b1;
            end
        end
    end

    always_comb begin
        tx_st_d     = tx_st_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_sh_d     = tx_sh_q;
        tx_d        = tx_q;
        resp_sent_d = 1'b0;
        unique case (tx_st_q)
            IDLE: begin
                tx_d = 1'b1;
                if (send_resp) begin
                    tx_sh_d  = resp_data;
                    tx_d     = 1'b0;
                    tx_st_d  = START;
                    tx_cnt_d = FULL;
                end
            end
            START: begin
                if (tx_cnt_q == '0) begin
                    tx_st_d  = DATA;
                    tx_d     = tx_sh_q[0];
                    tx_bit_d = 3'd0;
                    tx_cnt_d = FULL;
                end else begin
                    tx_cnt_d = tx_cnt_q - ONE;
                end
            end
            DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = FULL;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_d     = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - ONE;
                end
            end
            STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_st_d     = IDLE;
                    tx_d        = 1'b1;
                    resp_sent_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - ONE;
                end
            end
            default: tx_st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st_q     <= IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_sh_q     <= 8'h00;
            byte_cnt_q  <= 2'd0;
            cmd_q       <= 24'h000000;
            cmd_rdy_q   <= 1'b0;
            tx_st_q     <= IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 3'd0;
            tx_sh_q     <= 8'h00;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            rx_st_q     <= rx_st_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            byte_cnt_q  <= byte_cnt_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_st_q     <= tx_st_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule
